// File: rtl/dpram_128x8_fifo_ctrl.sv
// FIFO controller for an external 128x8 dual-port RAM with registered read data.
// The output word register is the RAM read register itself, so capacity is 128 + 1.
module dpram_128x8_fifo_ctrl #(
    parameter int unsigned AFULL_LEVEL = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       push_valid,
    input  logic [0:7] push_data,
    output logic       push_ready,
    output logic       pop_valid,
    output logic [0:7] pop_data,
    input  logic       pop_ready,
    output logic       ram_wen,
    output logic [0:6] ram_waddr,
    output logic [0:7] ram_data_in,
    output logic       ram_ren,
    output logic [0:6] ram_raddr,
    input  logic [0:7] ram_data_out,
    output logic [0:7] level,
    output logic       almost_full
);

    localparam logic [7:0] RAM_DEPTH = 8'd128;
    localparam logic [7:0] AFULL_L   = AFULL_LEVEL[7:0];

    logic [6:0] wptr;
    logic [6:0] rptr;
    logic [7:0] ram_count;
    logic [7:0] ram_count_nxt;
    logic       vld_p1;
    logic       vld_p1_nxt;
    logic       push_acc;
    logic       rd_issue;
    logic [7:0] level_i;

    // ram_count only covers words written on earlier edges, so a read never
    // targets the address being written in the same cycle.
    assign push_ready = !reset && (ram_count != RAM_DEPTH);
    assign push_acc   = push_valid && push_ready && !clear;
    assign rd_issue   = !reset && !clear && (ram_count != 8'd0) && (!vld_p1 || pop_ready);

    assign ram_wen     = push_acc;
    assign ram_waddr   = wptr;
    assign ram_data_in = push_data;
    assign ram_ren     = rd_issue;
    assign ram_raddr   = rptr;

    assign pop_valid   = vld_p1;
    assign pop_data    = ram_data_out;
    assign level_i     = ram_count + {7'd0, vld_p1};
    assign level       = level_i;
    assign almost_full = (level_i >= AFULL_L);

    always_comb begin
        ram_count_nxt = ram_count;
        vld_p1_nxt    = vld_p1;
        if (push_acc && !rd_issue) begin
            ram_count_nxt = ram_count + 8'd1;
        end else if (!push_acc && rd_issue) begin
            ram_count_nxt = ram_count - 8'd1;
        end
        if (rd_issue) begin
            vld_p1_nxt = 1'b1;
        end else if (pop_ready) begin
            vld_p1_nxt = 1'b0;
        end
    end

    // RAM read issue -> output word valid (RAM read register holds the data)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr      <= 7'd0;
            rptr      <= 7'd0;
            ram_count <= 8'd0;
            vld_p1    <= 1'b0;
        end else if (clear) begin
            wptr      <= 7'd0;
            rptr      <= 7'd0;
            ram_count <= 8'd0;
            vld_p1    <= 1'b0;
        end else begin
            if (push_acc) begin
                wptr <= wptr + 7'd1;
            end
            if (rd_issue) begin
                rptr <= rptr + 7'd1;
            end
            ram_count <= ram_count_nxt;
            vld_p1    <= vld_p1_nxt;
        end
    end

endmodule

// File: tb/tb_dpram_128x8_fifo_ctrl.sv
// Directed bench for dpram_128x8_fifo_ctrl with a behavioural 128x8 RAM model.
module tb_dpram_128x8_fifo_ctrl;

    logic       clk;
    logic       reset;
    logic       clear;
    logic       push_valid;
    logic [0:7] push_data;
    logic       push_ready;
    logic       pop_valid;
    logic [0:7] pop_data;
    logic       pop_ready;
    logic       ram_wen;
    logic [0:6] ram_waddr;
    logic [0:7] ram_data_in;
    logic       ram_ren;
    logic [0:6] ram_raddr;
    logic [0:7] ram_data_out;
    logic [0:7] level;
    logic       almost_full;

    int         checks;
    int         errors;
    logic [7:0] exp_q[$];
    logic [6:0] exp_w;
    logic [7:0] w;

    logic [7:0] mem [0:127];

    dpram_128x8_fifo_ctrl #(.AFULL_LEVEL(120)) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .push_valid   (push_valid),
        .push_data    (push_data),
        .push_ready   (push_ready),
        .pop_valid    (pop_valid),
        .pop_data     (pop_data),
        .pop_ready    (pop_ready),
        .ram_wen      (ram_wen),
        .ram_waddr    (ram_waddr),
        .ram_data_in  (ram_data_in),
        .ram_ren      (ram_ren),
        .ram_raddr    (ram_raddr),
        .ram_data_out (ram_data_out),
        .level        (level),
        .almost_full  (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_data_in;
        if (ram_ren) ram_data_out <= mem[ram_raddr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge; checks follow at edge+2.
    task automatic cyc(input logic pv, input logic [7:0] pd, input logic pr, input logic clr);
        @(posedge clk);
        #1;
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
        clear      = clr;
        #1;
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && exp_q.size() > 0; k++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            if (pop_valid) begin
                w = exp_q.pop_front();
                check("drain_data", pop_data, w);
            end
        end
        check("drain_done", exp_q.size(), 0);
    endtask

    initial begin
        checks = 0; errors = 0; exp_w = 7'd0;
        reset = 1'b1; clear = 1'b0; push_valid = 1'b0; push_data = 8'h00; pop_ready = 1'b0;
        #2;
        check("rst_push_ready", push_ready, 0);
        check("rst_wen", ram_wen, 0);
        check("rst_ren", ram_ren, 0);
        check("rst_level", level, 0);
        check("rst_afull", almost_full, 0);
        check("rst_pop_valid", pop_valid, 0);
        @(posedge clk); @(posedge clk); #1 reset = 1'b0; #1;
        check("idle_push_ready", push_ready, 1);

        // first-word latency
        cyc(1'b1, 8'h5A, 1'b0, 1'b0);
        check("fw_wen", ram_wen, 1);
        check("fw_waddr", ram_waddr, 0);
        check("fw_din", ram_data_in, 8'h5A);
        check("fw_ren0", ram_ren, 0);
        exp_w++;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("fw_ren1", ram_ren, 1);
        check("fw_raddr", ram_raddr, 0);
        check("fw_pv1", pop_valid, 0);
        check("fw_level1", level, 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("fw_pv2", pop_valid, 1);
        check("fw_data", pop_data, 8'h5A);
        check("fw_ren2", ram_ren, 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("fw_hold", pop_data, 8'h5A);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("fw_pop_ren", ram_ren, 0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("empty_pv", pop_valid, 0);
        check("empty_level", level, 0);
        check("empty_ren", ram_ren, 0);

        // fill to 129 with no pops
        for (int i = 0; i < 129; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
            check("fill_ready", push_ready, 1);
            check("fill_waddr", ram_waddr, exp_w);
            check("fill_level", level, i);
            check("fill_afull", almost_full, (i >= 120) ? 1 : 0);
            exp_w++;
            exp_q.push_back(8'(i));
        end
        cyc(1'b1, 8'hEE, 1'b0, 1'b0);
        check("full_ready", push_ready, 0);
        check("full_wen", ram_wen, 0);
        check("full_level", level, 129);
        check("full_afull", almost_full, 1);
        check("full_data", pop_data, 8'h00);

        // full: push refused while a read issues, accepted next cycle
        cyc(1'b1, 8'hC8, 1'b1, 1'b0);
        check("fp_ready", push_ready, 0);
        check("fp_wen", ram_wen, 0);
        check("fp_ren", ram_ren, 1);
        w = exp_q.pop_front();
        check("fp_data", pop_data, w);
        cyc(1'b1, 8'hC8, 1'b0, 1'b0);
        check("fp_ready2", push_ready, 1);
        check("fp_wen2", ram_wen, 1);
        check("fp_waddr2", ram_waddr, exp_w);
        exp_w++;
        exp_q.push_back(8'hC8);
        drain(300);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("fp_end_level", level, 0);
        check("fp_end_pv", pop_valid, 0);

        // streaming push and pop, pointers wrap twice
        for (int i = 0; i < 256; i++) begin
            cyc(1'b1, 8'(i), 1'b1, 1'b0);
            check("st_wen", ram_wen, 1);
            check("st_waddr", ram_waddr, exp_w);
            exp_w++;
            exp_q.push_back(8'(i));
            if (pop_valid) begin
                w = exp_q.pop_front();
                check("st_data", pop_data, w);
            end
            if (i >= 2) check("st_level", level, 2);
        end
        drain(10);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("st_end_level", level, 0);

        // clear with words queued and a read in flight
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("cl_ren", ram_ren, 1);
        check("cl_data", pop_data, 8'h10);
        check("cl_level", level, 10);
        cyc(1'b1, 8'h77, 1'b0, 1'b1);
        check("cl_wen", ram_wen, 0);
        check("cl_ren_sup", ram_ren, 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("cl_level0", level, 0);
        check("cl_pv0", pop_valid, 0);
        check("cl_ready", push_ready, 1);
        exp_q.delete();
        cyc(1'b1, 8'h33, 1'b0, 1'b0);
        check("cl_waddr", ram_waddr, 0);
        check("cl_wen2", ram_wen, 1);
        exp_q.push_back(8'h33);
        drain(6);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("cl_end_level", level, 0);

        // asynchronous reset mid-cycle with 5 words queued
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("ar_level5", level, 5);
        push_valid = 1'b1; push_data = 8'h99; pop_ready = 1'b1;
        #1 reset = 1'b1;
        #1;
        check("ar_ready", push_ready, 0);
        check("ar_wen", ram_wen, 0);
        check("ar_ren", ram_ren, 0);
        check("ar_level", level, 0);
        check("ar_afull", almost_full, 0);
        check("ar_pv", pop_valid, 0);
        @(posedge clk);
        #3 reset = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        check("ar_wen2", ram_wen, 1);
        check("ar_waddr", ram_waddr, 0);
        check("ar_level0", level, 0);
        exp_q.delete();
        exp_q.push_back(8'hA5);
        drain(6);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("ar_end_level", level, 0);
        check("ar_end_pv", pop_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpram_128x8_fifo_ctrl.md
DPRAM_128X8_FIFO_CTRL -- requirements
Module: dpram_128x8_fifo_ctrl

Interface
REQ-001 SHALL have parameter AFULL_LEVEL, default 120, meaning the occupancy at or above which almost_full asserts (legal range 1..129).
REQ-002 SHALL have port clk  input  1  single clock for all state; all flops on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port clear  input  1  synchronous flush, active-high.
REQ-005 SHALL have port push_valid  input  1  write request.
REQ-006 SHALL have port push_data  input  [0:7]  write data.
REQ-007 SHALL have port push_ready  output  1  controller accepts push this cycle.
REQ-008 SHALL have port pop_valid  output  1  pop_data holds a valid word.
REQ-009 SHALL have port pop_data  output  [0:7]  head-of-queue word.
REQ-010 SHALL have port pop_ready  input  1  consumer takes the word.
REQ-011 SHALL have ports ram_wen  output  1,  ram_waddr  output  [0:6],  ram_data_in  output  [0:7]  drive the write side of a 128x8 dual-port RAM on clk.
REQ-012 SHALL have ports ram_ren  output  1,  ram_raddr  output  [0:6]  drive the read side, and ram_data_out  input  [0:7]  RAM registered read data (1-cycle latency, held until the next ram_ren).
REQ-013 SHALL have port level  output  [0:7]  total occupancy, 0..129.
REQ-014 SHALL have port almost_full  output  1  level >= AFULL_LEVEL.

Function
REQ-015 SHALL keep a 7-bit write pointer wptr, a 7-bit read pointer rptr and an 8-bit ram_count (0..128) of words resident in the RAM.
REQ-016 SHALL drive push_ready = (ram_count != 128) and not reset, combinationally from registered state only.
REQ-017 SHALL, on push_valid and push_ready, assert ram_wen with ram_waddr = wptr and ram_data_in = push_data in that same cycle, and increment wptr modulo 128 (127 wraps to 0).
REQ-018 SHALL assert ram_ren with ram_raddr = rptr when ram_count != 0 and (pop_valid = 0 or pop_ready = 1), and increment rptr modulo 128.
REQ-019 SHALL never read an address written in the same cycle; a word pushed in cycle t is first readable in cycle t+1.
REQ-020 SHALL set pop_valid the cycle after ram_ren and clear it the cycle after a pop with no ram_ren in that pop cycle; pop_data SHALL equal ram_data_out.
REQ-021 SHALL update ram_count by +1 per accepted push, -1 per ram_ren, and leave it unchanged when both occur.
REQ-022 SHALL report level = ram_count + pop_valid.
REQ-023 SHALL give first-word fall-through latency of 2 cycles: push at t, ram_ren at t+1, pop_valid at t+2.
REQ-024 SHALL sustain one push and one pop per cycle in steady state.
REQ-025 SHALL, when full (ram_count = 128), refuse a push even if a read issues in the same cycle; push_ready returns the next cycle.
REQ-026 SHALL, when empty, hold pop_valid = 0 and ignore pop_ready.
REQ-027 SHALL, on clear, zero wptr, rptr, ram_count and pop_valid next cycle, suppress ram_wen and ram_ren in the clear cycle, and drop any word in flight.
REQ-028 SHALL keep pop_data stable while pop_valid = 1 and pop_ready = 0.

Reset
REQ-029 SHALL, while reset is high, force wptr = 0, rptr = 0, ram_count = 0, pop_valid = 0, push_ready = 0, ram_wen = 0, ram_ren = 0, level = 0, almost_full = 0, independent of clk.
REQ-030 SHALL discard any push or read in progress when reset asserts mid-operation, and resume as empty on the first clk edge after deassertion.

Verification
REQ-031 SHALL pass this test: push 0x5A at t with the FIFO empty -> ram_waddr = 0 at t; ram_ren with ram_raddr = 0 at t+1; pop_valid = 1 and pop_data = 0x5A at t+2.
REQ-032 SHALL pass this test: 129 back-to-back pushes with pop_ready = 0 -> push_ready = 0 after 129 accepted pushes (128 in RAM + 1 in output); level = 129; almost_full from level 120.
REQ-033 SHALL pass this test: continuous push and pop of 0..255 -> output equals input in order; pointers wrap 127->0 twice; level stays constant after fill.
REQ-034 SHALL pass this test: full FIFO with push_valid = 1 and pop_ready = 1 in the same cycle -> push refused that cycle, accepted the next; no data lost.
REQ-035 SHALL pass this test: clear with 10 words queued and a ram_ren in flight -> next cycle level = 0, pop_valid = 0; a subsequent push of 0x33 pops out as the first word.
REQ-036 SHALL pass this test: reset asserted between clock edges with 5 words queued -> outputs take their REQ-029 values immediately; after release, the first push 0xA5 pops as the first word.
